mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have input clk (1 bit), the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n (1 bit), an asynchronous, active-low reset.
REQ-004 The block SHALL have input start (1 bit), a request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have input sign_mode (1 bit): 1 means a and b are two's complement; 0 means unsigned.
REQ-006 The block SHALL have inputs a and b (WIDTH bits each), the multiplicand and multiplier, sampled with start.
REQ-007 The block SHALL have output busy (1 bit), high in every state except IDLE.
REQ-008 The block SHALL have output done (1 bit), a one-cycle pulse when a new result is valid.
REQ-009 The block SHALL have output z (2*WIDTH bits), the product register, held until the next result.
REQ-010 The block SHALL have output ZF (1 bit), high when the registered z equals 0.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and FIN, and reset SHALL force it to IDLE.
REQ-012 In IDLE with start=1 at a clock edge, the block SHALL make these captures and go to CALC:
- capture |a| and |b| as WIDTH-bit magnitudes (two's-complement negate when sign_mode=1 and the operand MSB=1; otherwise unchanged);
- capture result sign = a[MSB]^b[MSB] when sign_mode=1, or 0 otherwise;
- clear the 2*WIDTH-bit accumulator and the iteration counter.
REQ-013 The magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), represented exactly as an unsigned WIDTH-bit value with no truncation.
REQ-014 Each CALC cycle SHALL examine one multiplier bit, LSB first; when the bit is 1 it SHALL add the multiplicand shifted left by the iteration index into the accumulator.
REQ-015 CALC SHALL last exactly WIDTH cycles, then go to FIN.
REQ-016 In FIN the block SHALL do all of the following in one cycle, then return to IDLE:
- load z with the accumulator, or its two's-complement negation when the result sign is 1;
- load ZF with (result==0);
- assert done.
REQ-017 Latency SHALL be fixed: done is high during the cycle after edge WIDTH+1, counting the start-sampling edge as edge 0, independent of operand values.
REQ-018 z SHALL equal the exact mathematical product modulo 2^(2*WIDTH), with no overflow possible for any operand pair in either mode.
REQ-019 Zero product with a negative sign (for example 0*-3) SHALL give z=0 and ZF=1, never a negative zero.
REQ-020 start while busy=1 SHALL be ignored; operand changes during CALC/FIN SHALL not affect the result.
REQ-021 start high in the same cycle done is high (FIN) SHALL be ignored; a new operation begins only from an IDLE-sampled start.
REQ-022 start held continuously high SHALL launch back-to-back operations every WIDTH+2 cycles.
REQ-023 z and ZF SHALL change only in FIN or on reset.

Reset
REQ-024 On rst_n low, regardless of clk, the block SHALL force these values: state=IDLE, busy=0, done=0, z=0, ZF=1, accumulator=0, counter=0.
REQ-025 Reset asserted mid-CALC SHALL abandon the operation with no done pulse, and after release the block SHALL accept a new start normally.

Verification (WIDTH=4 unless stated)
REQ-026 The bench SHALL cover the signed extreme: sign_mode=1, a=4'b1000, b=4'b1000, start -> done 5 cycles later, z=8'h40, ZF=0.
REQ-027 The bench SHALL cover mixed sign: sign_mode=1, a=3, b=-5 (4'hB) -> z=8'hF1 (-15), ZF=0.
REQ-028 The bench SHALL cover unsigned full range: sign_mode=0, a=4'hF, b=4'hF -> z=8'hE1 (225); the same operands with sign_mode=1 -> z=8'h01.
REQ-029 The bench SHALL cover the zero case: sign_mode=1, a=0, b=-7 -> z=8'h00, ZF=1.
REQ-030 The bench SHALL cover busy and reset handling:
- start pulsed with new operands during CALC -> ignored, first result unchanged, exactly one done;
- rst_n low at CALC cycle 2 -> z=0, ZF=1, no done.
REQ-031 The bench SHALL cover WIDTH=8: sign_mode=1, a=-128, b=-128 -> z=16'h4000, done 9 cycles after start; plus a randomized sweep against a reference product in both modes.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier with signed/unsigned modes.
// In: clk, rst_n, start, sign_mode, a, b. Out: busy, done, z, ZF.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z,
  output logic               ZF
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               zf_q, zf_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] z_fin;

  // Unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (sign_mode && a[WIDTH-1]) a_mag = -a;
    if (sign_mode && b[WIDTH-1]) b_mag = -b;
  end

  // Negating zero yields zero, so no negative zero.
  always_comb begin
    z_fin = acc_q;
    if (neg_q) z_fin = -acc_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    z_d      = z_q;
    zf_d     = zf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // mcand_q is a << cnt_q; mplier_q[0] is b[cnt_q].
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        z_d     = z_fin;
        zf_d    = (z_fin == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
      zf_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      z_q      <= z_d;
      zf_q     <= zf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign z    = z_q;
  assign ZF   = zf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=4 and WIDTH=8.
// Vector table, hand sequences and a random sweep vs. a model.
module tb_mult_seq;

  logic       clk;
  logic       rst_n;
  logic       start4, sm4, busy4, done4, zf4;
  logic [3:0] a4, b4;
  logic [7:0] z4;
  logic       start8, sm8, busy8, done8, zf8;
  logic [7:0] a8, b8;
  logic [15:0] z8;

  int n_chk;
  int n_fail;

  mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sign_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .z(z4), .ZF(zf4)
  );

  mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sign_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8), .ZF(zf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] ez;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic, mod 2^(2w).
  function automatic longint ref_prod(int w, bit sm, longint a, longint b);
    longint sa, sb, m;
    sa = a;
    sb = b;
    if (sm && a[w-1]) sa = a - (longint'(1) << w);
    if (sm && b[w-1]) sb = b - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return (sa * sb) & m;
  endfunction

  // poke>0: pulse start with junk operands after edge poke.
  task automatic run4(input string nm, input logic sm,
                      input logic [3:0] a, input logic [3:0] b,
                      input int poke, input logic [7:0] ez);
    logic [7:0] zo, zprev;
    logic       zfo, hold_ok;
    int         lat, nd;
    @(negedge clk);
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    zprev = z4;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm;
    lat = -1; nd = 0; zo = '0; zfo = 1'b0; hold_ok = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (poke != 0 && i - 1 == poke) begin
        start4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
      end
      if (poke != 0 && i - 1 == poke + 1) start4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done4) begin
        if (nd == 0) begin
          lat = i; zo = z4; zfo = zf4;
        end
        nd++;
      end else if (nd == 0 && z4 !== zprev) begin
        hold_ok = 1'b0;
      end
    end
    start4 = 1'b0;
    chk({nm, " z"}, 32'(zo), 32'(ez));
    chk({nm, " zf"}, 32'(zfo), 32'(ez == 8'h00));
    chk({nm, " lat"}, lat, 5);
    chk({nm, " ndone"}, nd, 1);
    chk({nm, " zhold"}, 32'(hold_ok), 1);
  endtask

  task automatic run8(input string nm, input logic sm,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ez);
    logic [15:0] zo;
    logic        zfo;
    int          lat, nd;
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1; nd = 0; zo = '0; zfo = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        if (nd == 0) begin
          lat = i; zo = z8; zfo = zf8;
        end
        nd++;
      end
    end
    chk({nm, " z"}, 32'(zo), 32'(ez));
    chk({nm, " zf"}, 32'(zfo), 32'(ez == 16'h0));
    chk({nm, " lat"}, lat, 9);
    chk({nm, " ndone"}, nd, 1);
  endtask

  initial begin
    vec_t vt[$];
    int   dq[$];
    int   nd;
    logic sm;
    logic [3:0] ra4, rb4;
    logic [7:0] ra8, rb8;

    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;

    #12;
    chk("rst z4", 32'(z4), 0);
    chk("rst zf4", 32'(zf4), 1);
    chk("rst busy4", 32'(busy4), 0);
    chk("rst done4", 32'(done4), 0);
    chk("rst z8", 32'(z8), 0);
    chk("rst zf8", 32'(zf8), 1);
    @(negedge clk);
    rst_n = 1'b1;

    vt.push_back('{1'b1, 4'h8, 4'h8, 8'h40});
    vt.push_back('{1'b1, 4'h3, 4'hB, 8'hF1});
    vt.push_back('{1'b0, 4'hF, 4'hF, 8'hE1});
    vt.push_back('{1'b1, 4'hF, 4'hF, 8'h01});
    vt.push_back('{1'b1, 4'h0, 4'h9, 8'h00});
    vt.push_back('{1'b0, 4'h0, 4'h0, 8'h00});
    vt.push_back('{1'b0, 4'h1, 4'hF, 8'h0F});
    vt.push_back('{1'b1, 4'h7, 4'h8, 8'hC8});
    vt.push_back('{1'b1, 4'h8, 4'h7, 8'hC8});
    vt.push_back('{1'b0, 4'h8, 4'h8, 8'h40});
    foreach (vt[i])
      run4($sformatf("vec%0d", i), vt[i].sm, vt[i].a, vt[i].b, 0,
           vt[i].ez);

    run4("start_in_calc", 1'b0, 4'h3, 4'h5, 1, 8'h0F);
    run4("start_in_fin", 1'b0, 4'h6, 4'h7, 4, 8'h2A);

    // Start held high: done every WIDTH+2 cycles.
    @(negedge clk);
    sm4 = 1'b0; a4 = 4'h2; b4 = 4'h3; start4 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) dq.push_back(i);
      if (i < 19) @(posedge clk);
    end
    start4 = 1'b0;
    chk("b2b count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b d0", dq[0], 5);
      chk("b2b d1", dq[1], 11);
      chk("b2b d2", dq[2], 17);
    end
    chk("b2b z", 32'(z4), 32'h06);
    repeat (10) @(negedge clk);

    // Reset in CALC cycle 2 abandons the multiply.
    @(negedge clk);
    sm4 = 1'b0; a4 = 4'h5; b4 = 4'h3; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst z", 32'(z4), 0);
    chk("midrst zf", 32'(zf4), 1);
    chk("midrst busy", 32'(busy4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("midrst ndone", nd, 0);
    run4("after_rst", 1'b1, 4'h2, 4'hD, 0, 8'hFA);

    run8("w8 ext", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("w8 zero", 1'b1, 8'h00, 8'h85, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      sm = 1'(i % 2);
      ra4 = 4'($urandom); rb4 = 4'($urandom);
      run4($sformatf("r4_%0d", i), sm, ra4, rb4, 0,
           8'(ref_prod(4, sm, longint'(ra4), longint'(rb4))));
    end
    for (int i = 0; i < 120; i++) begin
      sm = 1'(i % 2);
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      run8($sformatf("r8_%0d", i), sm, ra8, rb8,
           16'(ref_prod(8, sm, longint'(ra8), longint'(rb8))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
